// File: rtl/commit_rob.sv
// commit_rob: in-order reorder buffer feeding the commit stage.
// Entries are allocated at the tail on issue, completed out of order by
// transaction id from the writeback ports, presented oldest-first on the
// commit ports, and retired from the head when the commit stage acks.
module commit_rob #(
  parameter int unsigned NrEntries     = 8,
  parameter int unsigned NrCommitPorts = 2,
  parameter int unsigned NrWbPorts     = 4,
  parameter int unsigned XLEN          = 64,
  parameter int unsigned VLEN          = 64,
  parameter int unsigned IDW           = $clog2(NrEntries)
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          flush_i,
  // issue
  input  logic                          issue_valid_i,
  output logic                          issue_ready_o,
  input  logic [VLEN-1:0]               issue_pc_i,
  input  logic [3:0]                    issue_fu_i,
  input  logic [7:0]                    issue_op_i,
  input  logic [4:0]                    issue_rd_i,
  output logic [IDW-1:0]                issue_trans_id_o,
  // writeback
  input  logic [NrWbPorts-1:0]          wb_valid_i,
  input  logic [NrWbPorts*IDW-1:0]      wb_trans_id_i,
  input  logic [NrWbPorts*XLEN-1:0]     wb_result_i,
  input  logic [NrWbPorts-1:0]          wb_ex_valid_i,
  input  logic [NrWbPorts*6-1:0]        wb_ex_cause_i,
  // commit
  output logic [NrCommitPorts-1:0]      commit_valid_o,
  output logic [NrCommitPorts*VLEN-1:0] commit_pc_o,
  output logic [NrCommitPorts*4-1:0]    commit_fu_o,
  output logic [NrCommitPorts*8-1:0]    commit_op_o,
  output logic [NrCommitPorts*5-1:0]    commit_rd_o,
  output logic [NrCommitPorts*XLEN-1:0] commit_result_o,
  output logic [NrCommitPorts-1:0]      commit_ex_valid_o,
  output logic [NrCommitPorts*6-1:0]    commit_ex_cause_o,
  output logic [NrCommitPorts*IDW-1:0]  commit_trans_id_o,
  input  logic [NrCommitPorts-1:0]      commit_ack_i,
  output logic [IDW:0]                  count_o
);

  localparam logic [IDW:0] FULL_CNT = (IDW+1)'(NrEntries);

  // control state
  logic [IDW-1:0]       head_q, head_d;
  logic [IDW-1:0]       tail_q, tail_d;
  logic [IDW:0]         count_q, count_d;
  logic [NrEntries-1:0] occ_q, occ_d;
  logic [NrEntries-1:0] done_q, done_d;

  // entry payload (not reset; only meaningful while occupied)
  logic [VLEN-1:0] pc_q   [NrEntries];
  logic [3:0]      fu_q   [NrEntries];
  logic [7:0]      op_q   [NrEntries];
  logic [4:0]      rd_q   [NrEntries];
  logic [XLEN-1:0] res_q  [NrEntries];
  logic            exv_q  [NrEntries];
  logic [5:0]      exc_q  [NrEntries];

  // per-entry writeback selection
  logic [NrEntries-1:0] wb_en;
  logic [XLEN-1:0]      wb_res [NrEntries];
  logic                 wb_exv [NrEntries];
  logic [5:0]           wb_exc [NrEntries];

  logic                 issue_fire;
  logic [IDW:0]         retired;
  logic [NrEntries-1:0] retire_mask;

  assign issue_ready_o    = (count_q < FULL_CNT);
  assign issue_fire       = issue_valid_i && issue_ready_o;
  assign issue_trans_id_o = tail_q;
  assign count_o          = count_q;

  // Commit view: port i shows entry head+i (wrapping), straight from registers.
  always_comb begin
    logic [IDW-1:0] cidx;
    cidx              = head_q;
    commit_valid_o    = '0;
    commit_pc_o       = '0;
    commit_fu_o       = '0;
    commit_op_o       = '0;
    commit_rd_o       = '0;
    commit_result_o   = '0;
    commit_ex_valid_o = '0;
    commit_ex_cause_o = '0;
    commit_trans_id_o = '0;
    for (int i = 0; i < NrCommitPorts; i++) begin
      cidx                               = head_q + IDW'(i);
      commit_valid_o[i]                  = occ_q[cidx] & done_q[cidx];
      commit_pc_o[i*VLEN +: VLEN]        = pc_q[cidx];
      commit_fu_o[i*4 +: 4]              = fu_q[cidx];
      commit_op_o[i*8 +: 8]              = op_q[cidx];
      commit_rd_o[i*5 +: 5]              = rd_q[cidx];
      commit_result_o[i*XLEN +: XLEN]    = res_q[cidx];
      commit_ex_valid_o[i]               = exv_q[cidx];
      commit_ex_cause_o[i*6 +: 6]        = exc_q[cidx];
      commit_trans_id_o[i*IDW +: IDW]    = cidx;
    end
  end

  // Retire count: length of the unbroken prefix of acks on valid ports.
  always_comb begin
    logic           run;
    logic [IDW-1:0] ridx;
    run         = 1'b1;
    ridx        = head_q;
    retired     = '0;
    retire_mask = '0;
    for (int i = 0; i < NrCommitPorts; i++) begin
      ridx = head_q + IDW'(i);
      if (run && commit_ack_i[i] && commit_valid_o[i]) begin
        retired           = retired + (IDW+1)'(1);
        retire_mask[ridx] = 1'b1;
      end else begin
        run = 1'b0;
      end
    end
  end

  // Writeback decode: only occupied entries accept; later ports override earlier.
  always_comb begin
    logic [IDW-1:0] wid;
    wid   = '0;
    wb_en = '0;
    for (int e = 0; e < NrEntries; e++) begin
      wb_res[e] = '0;
      wb_exv[e] = 1'b0;
      wb_exc[e] = '0;
    end
    for (int p = 0; p < NrWbPorts; p++) begin
      wid = wb_trans_id_i[p*IDW +: IDW];
      if (wb_valid_i[p] && occ_q[wid]) begin
        wb_en[wid]  = 1'b1;
        wb_res[wid] = wb_result_i[p*XLEN +: XLEN];
        wb_exv[wid] = wb_ex_valid_i[p];
        wb_exc[wid] = wb_ex_cause_i[p*6 +: 6];
      end
    end
  end

  // Next control state: writeback, then retire, then allocate; flush overrides all.
  always_comb begin
    head_d  = head_q + retired[IDW-1:0];
    tail_d  = tail_q + IDW'(issue_fire);
    count_d = count_q + (IDW+1)'(issue_fire) - retired;
    done_d  = (done_q | wb_en) & ~retire_mask;
    occ_d   = occ_q & ~retire_mask;
    if (issue_fire) begin
      occ_d[tail_q]  = 1'b1;
      done_d[tail_q] = 1'b0;
    end
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      occ_d   = '0;
      done_d  = '0;
    end
  end

  // Control registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      occ_q   <= '0;
      done_q  <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      occ_q   <= occ_d;
      done_q  <= done_d;
    end
  end

  // Payload registers: capture issue fields at the tail and writeback results.
  always_ff @(posedge clk_i) begin
    if (issue_fire) begin
      pc_q[tail_q]  <= issue_pc_i;
      fu_q[tail_q]  <= issue_fu_i;
      op_q[tail_q]  <= issue_op_i;
      rd_q[tail_q]  <= issue_rd_i;
      exv_q[tail_q] <= 1'b0;
    end
    for (int e = 0; e < NrEntries; e++) begin
      if (wb_en[e]) begin
        res_q[e] <= wb_res[e];
        exv_q[e] <= wb_exv[e];
        exc_q[e] <= wb_exc[e];
      end
    end
  end

endmodule

// File: tb/tb_commit_rob.sv
// Directed bench for commit_rob with default parameters (8 entries, 2 commit
// ports, 4 writeback ports, 64-bit data).
module tb_commit_rob;

  localparam int NE = 8;
  localparam int NC = 2;
  localparam int NW = 4;
  localparam int XL = 64;
  localparam int VL = 64;
  localparam int ID = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic            flush;
  logic            issue_valid;
  logic            issue_ready;
  logic [VL-1:0]   issue_pc;
  logic [3:0]      issue_fu;
  logic [7:0]      issue_op;
  logic [4:0]      issue_rd;
  logic [ID-1:0]   issue_tid;
  logic [NW-1:0]   wb_valid;
  logic [NW*ID-1:0] wb_tid;
  logic [NW*XL-1:0] wb_result;
  logic [NW-1:0]   wb_exv;
  logic [NW*6-1:0] wb_exc;
  logic [NC-1:0]   c_valid;
  logic [NC*VL-1:0] c_pc;
  logic [NC*4-1:0] c_fu;
  logic [NC*8-1:0] c_op;
  logic [NC*5-1:0] c_rd;
  logic [NC*XL-1:0] c_result;
  logic [NC-1:0]   c_exv;
  logic [NC*6-1:0] c_exc;
  logic [NC*ID-1:0] c_tid;
  logic [NC-1:0]   c_ack;
  logic [ID:0]     count;

  int n_tests = 0;
  int n_fail  = 0;

  commit_rob dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .flush_i           (flush),
    .issue_valid_i     (issue_valid),
    .issue_ready_o     (issue_ready),
    .issue_pc_i        (issue_pc),
    .issue_fu_i        (issue_fu),
    .issue_op_i        (issue_op),
    .issue_rd_i        (issue_rd),
    .issue_trans_id_o  (issue_tid),
    .wb_valid_i        (wb_valid),
    .wb_trans_id_i     (wb_tid),
    .wb_result_i       (wb_result),
    .wb_ex_valid_i     (wb_exv),
    .wb_ex_cause_i     (wb_exc),
    .commit_valid_o    (c_valid),
    .commit_pc_o       (c_pc),
    .commit_fu_o       (c_fu),
    .commit_op_o       (c_op),
    .commit_rd_o       (c_rd),
    .commit_result_o   (c_result),
    .commit_ex_valid_o (c_exv),
    .commit_ex_cause_o (c_exc),
    .commit_trans_id_o (c_tid),
    .commit_ack_i      (c_ack),
    .count_o           (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_in();
    flush       = 1'b0;
    issue_valid = 1'b0;
    issue_pc    = '0;
    issue_fu    = '0;
    issue_op    = '0;
    issue_rd    = '0;
    wb_valid    = '0;
    wb_tid      = '0;
    wb_result   = '0;
    wb_exv      = '0;
    wb_exc      = '0;
    c_ack       = '0;
  endtask

  // advance one clock; inputs are dropped right after the edge
  task automatic step();
    @(posedge clk);
    #1;
    clear_in();
  endtask

  task automatic set_issue(input logic [VL-1:0] pc);
    issue_valid = 1'b1;
    issue_pc    = pc;
    issue_fu    = 4'h3;
    issue_op    = 8'h21;
    issue_rd    = 5'd7;
  endtask

  task automatic set_wb(input int p, input logic [ID-1:0] id, input logic [XL-1:0] res,
                        input logic exv, input logic [5:0] exc);
    wb_valid[p]          = 1'b1;
    wb_tid[p*ID +: ID]   = id;
    wb_result[p*XL +: XL] = res;
    wb_exv[p]            = exv;
    wb_exc[p*6 +: 6]     = exc;
  endtask

  initial begin
    clear_in();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;

    // reset state
    check("rst_ready", 64'(issue_ready), 64'd1);
    check("rst_tid",   64'(issue_tid),   64'd0);
    check("rst_count", 64'(count),       64'd0);
    check("rst_cvalid", 64'(c_valid),    64'd0);

    // issue three: ids 0,1,2
    for (int k = 0; k < 3; k++) begin
      check($sformatf("iss_tid%0d", k), 64'(issue_tid), 64'(k));
      set_issue(64'h1000 + 64'(4*k));
      step();
    end
    check("iss3_count", 64'(count), 64'd3);
    check("iss3_cvalid", 64'(c_valid), 64'd0);

    // id 1 completes first: head still blocked
    set_wb(0, 3'd1, 64'h11, 1'b0, 6'd0);
    step();
    check("wb1_cvalid0", 64'(c_valid[0]), 64'd0);
    check("wb1_cvalid", 64'(c_valid), 64'b10);

    set_wb(1, 3'd0, 64'h10, 1'b0, 6'd0);
    step();
    check("wb0_cvalid", 64'(c_valid), 64'b11);
    check("wb0_pc0", c_pc[63:0], 64'h1000);
    check("wb0_pc1", c_pc[127:64], 64'h1004);
    check("wb0_res0", c_result[63:0], 64'h10);
    check("wb0_res1", c_result[127:64], 64'h11);

    // broken ack prefix retires nothing
    c_ack = 2'b10;
    step();
    check("ack10_count", 64'(count), 64'd3);
    check("ack10_cvalid", 64'(c_valid), 64'b11);

    c_ack = 2'b11;
    step();
    check("ack11_count", 64'(count), 64'd1);
    check("ack11_tid0", 64'(c_tid[2:0]), 64'd2);
    check("ack11_cvalid", 64'(c_valid), 64'b00);
    check("ack11_itid", 64'(issue_tid), 64'd3);

    // ports 0 and 3 hit id 2: port 3 wins; port 1 hits unoccupied id 5
    set_wb(0, 3'd2, 64'hA, 1'b0, 6'd0);
    set_wb(3, 3'd2, 64'hB, 1'b0, 6'd0);
    set_wb(1, 3'd5, 64'h55, 1'b0, 6'd0);
    step();
    check("dup_cvalid", 64'(c_valid), 64'b01);
    check("dup_res", c_result[63:0], 64'hB);
    check("unocc_count", 64'(count), 64'd1);

    c_ack = 2'b01;
    step();
    check("ret2_count", 64'(count), 64'd0);

    // fill all eight: ids 3,4,5,6,7,0,1,2
    for (int k = 0; k < NE; k++) begin
      check($sformatf("fill_tid%0d", k), 64'(issue_tid), 64'((3 + k) % NE));
      set_issue(64'h2000 + 64'(4*k));
      step();
    end
    check("full_count", 64'(count), 64'd8);
    check("full_ready", 64'(issue_ready), 64'd0);

    // issue while full is dropped
    set_issue(64'hDEAD);
    step();
    check("full_drop_count", 64'(count), 64'd8);
    check("full_drop_tid", 64'(issue_tid), 64'd3);

    // exceptions on both commit ports (ids 3 and 4)
    set_wb(2, 3'd3, 64'h33, 1'b1, 6'd13);
    set_wb(0, 3'd4, 64'h44, 1'b1, 6'd7);
    step();
    check("ex_cvalid", 64'(c_valid), 64'b11);
    check("ex_valid0", 64'(c_exv[0]), 64'd1);
    check("ex_cause0", 64'(c_exc[5:0]), 64'd13);
    check("ex_valid1", 64'(c_exv[1]), 64'd1);
    check("ex_cause1", 64'(c_exc[11:6]), 64'd7);

    // full with same-cycle ack: issue still refused
    check("fullack_ready", 64'(issue_ready), 64'd0);
    c_ack = 2'b01;
    set_issue(64'hBEEF);
    step();
    check("fullack_count", 64'(count), 64'd7);
    check("fullack_ready1", 64'(issue_ready), 64'd1);
    check("fullack_tid", 64'(issue_tid), 64'd3);
    check("fullack_pc0", c_pc[63:0], 64'h2004);
    check("fullack_ctid0", 64'(c_tid[2:0]), 64'd4);

    // complete ids 5,6,7,0 and retire up to head 7 to see port 1 wrap to entry 0
    set_wb(0, 3'd5, 64'h5, 1'b0, 6'd0);
    set_wb(1, 3'd6, 64'h6, 1'b0, 6'd0);
    set_wb(2, 3'd7, 64'h7, 1'b0, 6'd0);
    set_wb(3, 3'd0, 64'h8, 1'b0, 6'd0);
    c_ack = 2'b01;
    step();
    check("wrap_count6", 64'(count), 64'd6);
    c_ack = 2'b11;
    step();
    check("wrap_count4", 64'(count), 64'd4);
    check("wrap_cvalid", 64'(c_valid), 64'b11);
    check("wrap_ctid1", 64'(c_tid[5:3]), 64'd0);
    check("wrap_pc0", c_pc[63:0], 64'h2010);
    check("wrap_pc1", c_pc[127:64], 64'h2014);
    check("wrap_res1", c_result[127:64], 64'h8);

    // flush overrides issue, writeback and ack
    flush = 1'b1;
    set_issue(64'h3000);
    set_wb(0, 3'd1, 64'h99, 1'b0, 6'd0);
    c_ack = 2'b11;
    step();
    check("flush_count", 64'(count), 64'd0);
    check("flush_cvalid", 64'(c_valid), 64'd0);
    check("flush_tid", 64'(issue_tid), 64'd0);
    check("flush_ready", 64'(issue_ready), 64'd1);

    // writeback in the issue cycle to the id being issued is ignored
    set_issue(64'h4000);
    set_wb(0, 3'd0, 64'h77, 1'b0, 6'd0);
    step();
    check("post_count", 64'(count), 64'd1);
    check("post_cvalid", 64'(c_valid), 64'd0);
    set_wb(0, 3'd0, 64'h78, 1'b0, 6'd0);
    step();
    check("post_cvalid2", 64'(c_valid), 64'b01);
    check("post_pc0", c_pc[63:0], 64'h4000);
    check("post_res0", c_result[63:0], 64'h78);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
